// File: rtl/zion_basic_circuit_lib_skid_reg_pkg.sv
// Shared types for the Zion basic circuit library.
// Holds the skid register state encoding.
package ZionBasicCircuitLib_Pkg;

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FULL
    } SkidState_t;

endpackage

// File: rtl/zion_basic_circuit_lib_skid_reg_dff.sv
// Enabled DFF with synchronous, active-high reset.
// Used for the main and skid data registers of the skid slice.
module zion_basic_circuit_lib_skid_reg_dff #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] INI = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= INI;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/zion_basic_circuit_lib_skid_reg.sv
// Full-throughput valid/ready register slice with a two-entry skid buffer.
// oVld, oRdy and oDat all come straight from flops.
`ifndef ZionBasicCircuitLib_SkidReg
`define ZionBasicCircuitLib_SkidReg(UnitName_, clk_, rst_, iVld_, oRdy_, iDat_, oVld_, iRdy_, oDat_, INI_DATA_='0) \
    zion_basic_circuit_lib_skid_reg #( \
        .WIDTH($bits(iDat_)), \
        .INI_DATA(INI_DATA_) \
    ) UnitName_ ( \
        .clk(clk_), \
        .rst(rst_), \
        .iVld(iVld_), \
        .oRdy(oRdy_), \
        .iDat(iDat_), \
        .oVld(oVld_), \
        .iRdy(iRdy_), \
        .oDat(oDat_) \
    );
`endif

module zion_basic_circuit_lib_skid_reg
    import ZionBasicCircuitLib_Pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat
);

    if (WIDTH < 1) begin : g_width_chk
`ifdef CHECK_ERR_EXIT
        $fatal(1, "zion_basic_circuit_lib_skid_reg: WIDTH must be >= 1");
`else
        $error("zion_basic_circuit_lib_skid_reg: WIDTH must be >= 1");
`endif
    end

    SkidState_t       state;
    logic             acc;
    logic             dlv;
    logic             m_en;
    logic             s_en;
    logic [WIDTH-1:0] m_nxt;
    logic [WIDTH-1:0] sDat;

    assign acc = iVld & oRdy;
    assign dlv = oVld & iRdy;

    // Main register refills from the skid entry when draining FULL.
    always_comb begin
        m_en  = 1'b0;
        s_en  = 1'b0;
        m_nxt = iDat;
        unique case (state)
            EMPTY: begin
                m_en = acc;
            end
            BUSY: begin
                m_en = acc & dlv;
                s_en = acc & ~dlv;
            end
            FULL: begin
                m_en  = dlv;
                m_nxt = sDat;
            end
            default: begin
                m_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            oVld  <= 1'b0;
            oRdy  <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        state <= BUSY;
                        oVld  <= 1'b1;
                        oRdy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (acc & ~dlv) begin
                        state <= FULL;
                        oRdy  <= 1'b0;
                    end else if (~acc & dlv) begin
                        state <= EMPTY;
                        oVld  <= 1'b0;
                    end
                end
                FULL: begin
                    if (dlv) begin
                        state <= BUSY;
                        oRdy  <= 1'b1;
                    end
                end
                default: begin
                    state <= EMPTY;
                    oVld  <= 1'b0;
                    oRdy  <= 1'b1;
                end
            endcase
        end
    end

    zion_basic_circuit_lib_skid_reg_dff #(
        .WIDTH(WIDTH),
        .INI  (INI_DATA)
    ) u_main (
        .clk(clk),
        .rst(rst),
        .en (m_en),
        .d  (m_nxt),
        .q  (oDat)
    );

    zion_basic_circuit_lib_skid_reg_dff #(
        .WIDTH(WIDTH),
        .INI  (INI_DATA)
    ) u_skid (
        .clk(clk),
        .rst(rst),
        .en (s_en),
        .d  (iDat),
        .q  (sDat)
    );

endmodule

// File: tb/tb_zion_basic_circuit_lib_skid_reg.sv
// Bench for the skid register slice: queue model of buffered beats,
// per-cycle compare, directed stream/backpressure/reset cases and random traffic.
module tb_zion_basic_circuit_lib_skid_reg;

    localparam int         W   = 8;
    localparam logic [7:0] INI = 8'h5A;

    logic         clk = 1'b0;
    logic         rst;
    logic         iVld;
    logic         oRdy;
    logic [W-1:0] iDat;
    logic         oVld;
    logic         iRdy;
    logic [W-1:0] oDat;

    always #5 clk = ~clk;

    zion_basic_circuit_lib_skid_reg #(
        .WIDTH   (W),
        .INI_DATA(INI)
    ) dut (
        .clk (clk),
        .rst (rst),
        .iVld(iVld),
        .oRdy(oRdy),
        .iDat(iDat),
        .oVld(oVld),
        .iRdy(iRdy),
        .oDat(oDat)
    );

    int         compared   = 0;
    int         mismatched = 0;
    int         cyc        = 0;
    bit         chk_en     = 1'b0;
    logic [7:0] mq[$];
    logic [7:0] log_q[$];
    int         log_cyc[$];
    bit         m_vld;
    bit         m_rdy;
    bit         prev_hold  = 1'b0;
    logic [7:0] prev_dat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the slice holds an in-order queue of at most two beats.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
        end else begin
            m_vld = mq.size() > 0;
            m_rdy = mq.size() < 2;
            if (m_vld && iRdy) void'(mq.pop_front());
            if (iVld && m_rdy) mq.push_back(iDat);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("oVld", oVld, mq.size() > 0);
            chk("oRdy", oRdy, mq.size() < 2);
            if (mq.size() > 0) chk("oDat", oDat, mq[0]);
            if (prev_hold) chk("oDat_stable", oDat, prev_dat);
            prev_hold = oVld && !iRdy && !rst;
            prev_dat  = oDat;
            if (oVld && iRdy && !rst) begin
                log_q.push_back(oDat);
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        iVld = v;
        iDat = d;
        iRdy = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        rst  = 1'b1;
        iVld = 1'b0;
        iDat = '0;
        iRdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("rst_oVld", oVld, 0);
        chk("rst_oRdy", oRdy, 1);
        chk("rst_oDat", oDat, 8'h5A);
        step(1'b0, 8'h00, 1'b1);
        chk("idle_oDat", oDat, 8'h5A);

        // Full-rate stream
        log_q.delete();
        log_cyc.delete();
        step(1'b1, 8'h01, 1'b1);
        c0 = cyc;
        chk("stream_first_vld", oVld, 1);
        chk("stream_first_dat", oDat, 8'h01);
        for (int i = 2; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b1);
            chk("stream_rdy", oRdy, 1);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("stream_count", log_q.size(), 16);
        for (int k = 0; k < 16 && k < log_q.size(); k++) begin
            chk("stream_dat", log_q[k], k + 1);
            chk("stream_cyc", log_cyc[k], c0 + k);
        end

        // Backpressure into the skid entry
        log_q.delete();
        log_cyc.delete();
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        chk("bp_rdy_low", oRdy, 0);
        chk("bp_main", oDat, 8'hA1);
        step(1'b1, 8'hA3, 1'b0);
        chk("bp_hold_rdy", oRdy, 0);
        chk("bp_hold_main", oDat, 8'hA1);
        step(1'b1, 8'hA3, 1'b1);
        step(1'b1, 8'hA3, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("bp_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("bp_dat0", log_q[0], 8'hA1);
            chk("bp_dat1", log_q[1], 8'hA2);
            chk("bp_dat2", log_q[2], 8'hA3);
            chk("bp_gap1", log_cyc[1] - log_cyc[0], 1);
            chk("bp_gap2", log_cyc[2] - log_cyc[1], 1);
        end

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom % 2), 8'($urandom), 1'($urandom % 2));
        end
        repeat (4) step(1'b0, 8'h00, 1'b1);
        chk("drain_vld", oVld, 0);

        // Reset while FULL discards both beats
        step(1'b1, 8'hB1, 1'b0);
        step(1'b1, 8'hB2, 1'b0);
        chk("full_rdy", oRdy, 0);
        chk("full_main", oDat, 8'hB1);
        log_q.delete();
        log_cyc.delete();
        rst = 1'b1;
        step(1'b1, 8'hC3, 1'b1);
        rst = 1'b0;
        chk("mid_rst_vld", oVld, 0);
        chk("mid_rst_rdy", oRdy, 1);
        chk("mid_rst_dat", oDat, 8'h5A);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        chk("mid_rst_nodeliver", log_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
